// File: rtl/sargantana_icache_pkg.sv
// Shared constants and types for the instruction-cache storage array.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY  = 4;
  localparam int ICACHE_N_SETS = 64;
  localparam int TAG_WIDHT     = 20;
  localparam int WAY_WIDHT     = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } icache_mem_state_t;

endpackage

// File: rtl/sargantana_icache_mem_array_if.sv
// Request/response bundle between the icache controller and the storage array.
interface sargantana_icache_mem_array_if #(
  parameter int N_WAYS = 4,
  parameter int N_SETS = 64,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 128
);
  localparam int IDX_W = $clog2(N_SETS);

  logic                             req_i;
  logic                             we_i;
  logic [N_WAYS-1:0]                way_sel_i;
  logic [IDX_W-1:0]                 idx_i;
  logic [TAG_W-1:0]                 tag_i;
  logic [LINE_W-1:0]                line_i;
  logic                             flush_i;
  logic                             ready_o;
  logic                             busy_o;
  logic                             flush_done_o;
  logic                             rd_valid_o;
  logic [N_WAYS-1:0][TAG_W-1:0]     tag_way_o;
  logic [N_WAYS-1:0][LINE_W-1:0]    line_way_o;
  logic [N_WAYS-1:0]                vbit_way_o;

  modport master (
    output req_i, we_i, way_sel_i, idx_i, tag_i, line_i, flush_i,
    input  ready_o, busy_o, flush_done_o, rd_valid_o, tag_way_o, line_way_o, vbit_way_o
  );

  modport slave (
    input  req_i, we_i, way_sel_i, idx_i, tag_i, line_i, flush_i,
    output ready_o, busy_o, flush_done_o, rd_valid_o, tag_way_o, line_way_o, vbit_way_o
  );

endinterface

// File: rtl/sargantana_icache_way_array.sv
// One cache way: tag/data storage without reset, valid bits with async reset and per-set clear.
module sargantana_icache_way_array #(
  parameter int N_SETS = 64,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 128,
  localparam int IDX_W = $clog2(N_SETS)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  clr_idx_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  output logic              vbit_o
);

  logic [TAG_W-1:0]  r_tag_mem  [N_SETS];
  logic [LINE_W-1:0] r_line_mem [N_SETS];
  logic [N_SETS-1:0] r_valid;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_tag_mem[idx_i]  <= tag_i;
      r_line_mem[idx_i] <= line_i;
    end
  end

  // Writes and flush clears never overlap: requests are only accepted outside FLUSH.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= '0;
    end else begin
      if (we_i)  r_valid[idx_i]     <= 1'b1;
      if (clr_i) r_valid[clr_idx_i] <= 1'b0;
    end
  end

  assign tag_o  = r_tag_mem[idx_i];
  assign line_o = r_line_mem[idx_i];
  assign vbit_o = r_valid[idx_i];

endmodule

// File: rtl/sargantana_icache_mem_array.sv
// N-way icache storage with registered read port and a sequential valid-bit flush engine.
module sargantana_icache_mem_array
  import sargantana_icache_pkg::*;
#(
  parameter int N_WAYS = ICACHE_N_WAY,
  parameter int N_SETS = ICACHE_N_SETS,
  parameter int TAG_W  = TAG_WIDHT,
  parameter int LINE_W = WAY_WIDHT,
  localparam int IDX_W = $clog2(N_SETS)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  sargantana_icache_mem_array_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(N_SETS - 1);

  icache_mem_state_t             r_state, w_state_next;
  logic [IDX_W-1:0]              r_cnt, w_cnt_next;
  logic                          w_done_next, r_flush_done;
  logic                          w_accept, w_rd, w_wr, w_clr;
  logic [N_WAYS-1:0][TAG_W-1:0]  w_tag_rd, r_tag_way;
  logic [N_WAYS-1:0][LINE_W-1:0] w_line_rd, r_line_way;
  logic [N_WAYS-1:0]             w_vbit_rd, r_vbit_way;
  logic                          r_rd_valid;

  assign w_accept = bus.req_i && (r_state == IDLE);
  assign w_rd     = w_accept && !bus.we_i;
  assign w_wr     = w_accept && bus.we_i;
  assign w_clr    = (r_state == FLUSH);

  generate
    for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_way
      sargantana_icache_way_array #(
        .N_SETS (N_SETS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
      ) u_way (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .we_i      (w_wr && bus.way_sel_i[gi]),
        .idx_i     (bus.idx_i),
        .tag_i     (bus.tag_i),
        .line_i    (bus.line_i),
        .clr_i     (w_clr),
        .clr_idx_i (r_cnt),
        .tag_o     (w_tag_rd[gi]),
        .line_o    (w_line_rd[gi]),
        .vbit_o    (w_vbit_rd[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.flush_i) begin
          w_state_next = FLUSH;
          w_cnt_next   = '0;
        end
      end
      FLUSH: begin
        // flush_i is deliberately ignored here so a re-pulse cannot restart the walk
        if (r_cnt == LAST_SET) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_tag_way    <= '0;
      r_line_way   <= '0;
      r_vbit_way   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_flush_done <= w_done_next;
      r_rd_valid   <= w_rd;
      if (w_rd) begin
        r_tag_way  <= w_tag_rd;
        r_line_way <= w_line_rd;
        r_vbit_way <= w_vbit_rd;
      end
    end
  end

  assign bus.ready_o      = (r_state == IDLE);
  assign bus.busy_o       = (r_state == FLUSH);
  assign bus.flush_done_o = r_flush_done;
  assign bus.rd_valid_o   = r_rd_valid;
  assign bus.tag_way_o    = r_tag_way;
  assign bus.line_way_o   = r_line_way;
  assign bus.vbit_way_o   = r_vbit_way;

endmodule

// File: tb/tb_sargantana_icache_mem_array.sv
// Randomized and directed checks of the icache storage array against a behavioural set/way model.
module tb_sargantana_icache_mem_array;

  localparam int NW = 4;
  localparam int NS = 64;
  localparam int TW = 20;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sargantana_icache_mem_array_if #(.N_WAYS(NW), .N_SETS(NS), .TAG_W(TW), .LINE_W(LW)) bus ();

  sargantana_icache_mem_array #(.N_WAYS(NW), .N_SETS(NS), .TAG_W(TW), .LINE_W(LW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  logic [TW-1:0] m_tag     [NW][NS];
  logic [LW-1:0] m_line    [NW][NS];
  bit            m_valid   [NW][NS];
  bit            m_written [NW][NS];
  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] model_vbits(input int idx);
    logic [NW-1:0] v;
    for (int w = 0; w < NW; w++) v[w] = m_valid[w][idx];
    return v;
  endfunction

  task automatic check_read_data(input int idx);
    check("vbit", bus.vbit_way_o, model_vbits(idx));
    for (int w = 0; w < NW; w++) begin
      if (m_written[w][idx]) begin
        check("tag", bus.tag_way_o[w], m_tag[w][idx]);
        check("line", bus.line_way_o[w], m_line[w][idx]);
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", bus.ready_o, 1);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.flush_done_o, 0);
    check("rst_rdvalid", bus.rd_valid_o, 0);
    check("rst_vbit", bus.vbit_way_o, 0);
    for (int w = 0; w < NW; w++) begin
      check("rst_tag", bus.tag_way_o[w], 0);
      check("rst_line", bus.line_way_o[w], 0);
    end
  endtask

  task automatic clear_model_valid();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) m_valid[w][s] = 0;
  endtask

  task automatic model_write(input int way, input int idx, input logic [TW-1:0] tag, input logic [LW-1:0] line);
    m_tag[way][idx]     = tag;
    m_line[way][idx]    = line;
    m_valid[way][idx]   = 1;
    m_written[way][idx] = 1;
  endtask

  task automatic do_read(input int idx);
    logic [NW-1:0] snap;
    check("ready_before_rd", bus.ready_o, 1);
    bus.req_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.idx_i = 6'(idx);
    tick();
    bus.req_i = 1'b0;
    check("rd_valid", bus.rd_valid_o, 1);
    check_read_data(idx);
    snap = model_vbits(idx);
    $display("read  set=%0d vbit=%b", idx, bus.vbit_way_o);
    tick();
    check("rd_valid_low", bus.rd_valid_o, 0);
    check("vbit_hold", bus.vbit_way_o, snap);
  endtask

  task automatic do_write(input int way, input int idx, input logic [TW-1:0] tag, input logic [LW-1:0] line);
    check("ready_before_wr", bus.ready_o, 1);
    bus.req_i     = 1'b1;
    bus.we_i      = 1'b1;
    bus.way_sel_i = 4'(1 << way);
    bus.idx_i     = 6'(idx);
    bus.tag_i     = tag;
    bus.line_i    = line;
    tick();
    bus.req_i = 1'b0;
    model_write(way, idx, tag, line);
    check("wr_no_rdvalid", bus.rd_valid_o, 0);
    $display("write way=%0d set=%0d tag=%0h", way, idx, tag);
  endtask

  // disturb: hold a read request from busy cycle 10 and re-pulse flush_i at busy cycle 20
  task automatic do_flush(input bit with_write, input int way, input int idx,
                          input logic [TW-1:0] tag, input logic [LW-1:0] line,
                          input bit disturb, input int hold_idx);
    int busy_cnt = 0;
    int guard = 0;
    bus.flush_i = 1'b1;
    if (with_write) begin
      bus.req_i     = 1'b1;
      bus.we_i      = 1'b1;
      bus.way_sel_i = 4'(1 << way);
      bus.idx_i     = 6'(idx);
      bus.tag_i     = tag;
      bus.line_i    = line;
    end
    tick();
    bus.flush_i = 1'b0;
    bus.req_i   = 1'b0;
    if (with_write) model_write(way, idx, tag, line);
    while (bus.busy_o === 1'b1 && guard < 200) begin
      busy_cnt++;
      guard++;
      check("done_during_busy", bus.flush_done_o, 0);
      check("ready_during_busy", bus.ready_o, 0);
      if (disturb) begin
        check("rdvalid_during_busy", bus.rd_valid_o, 0);
        if (busy_cnt == 10) begin
          bus.req_i = 1'b1;
          bus.we_i  = 1'b0;
          bus.idx_i = 6'(hold_idx);
        end
        bus.flush_i = (busy_cnt == 20);
      end
      tick();
    end
    bus.flush_i = 1'b0;
    check("busy_cycles", busy_cnt, NS);
    check("flush_done", bus.flush_done_o, 1);
    check("ready_after", bus.ready_o, 1);
    clear_model_valid();
    $display("flush busy_cycles=%0d write=%0d disturb=%0d", busy_cnt, with_write, disturb);
    if (disturb) begin
      check("held_not_yet", bus.rd_valid_o, 0);
      tick();
      bus.req_i = 1'b0;
      check("held_rd_valid", bus.rd_valid_o, 1);
      check_read_data(hold_idx);
    end else begin
      tick();
    end
    check("done_one_pulse", bus.flush_done_o, 0);
    check("not_busy", bus.busy_o, 0);
  endtask

  initial begin
    rstn          = 1'b0;
    bus.req_i     = 1'b0;
    bus.we_i      = 1'b0;
    bus.way_sel_i = '0;
    bus.idx_i     = '0;
    bus.tag_i     = '0;
    bus.line_i    = '0;
    bus.flush_i   = 1'b0;
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) begin
        m_valid[w][s]   = 0;
        m_written[w][s] = 0;
        m_tag[w][s]     = '0;
        m_line[w][s]    = '0;
      end
    repeat (3) tick();
    check_reset_outputs();
    rstn = 1'b1;
    tick();
    check_reset_outputs();

    do_read(5);
    do_write(2, 10, 20'hABCDE, 128'h0123_4567_89AB_CDEF_0000_0000_0000_1234);
    do_read(10);

    for (int w = 0; w < NW; w++) begin
      do_write(w, 0, TW'($urandom), {$urandom, $urandom, $urandom, $urandom});
      do_write(w, 63, TW'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end
    do_read(0);
    do_read(63);
    do_flush(0, 0, 0, '0, '0, 0, 0);
    do_read(0);
    do_read(63);

    do_write(3, 12, TW'($urandom), {$urandom, $urandom, $urandom, $urandom});
    do_flush(0, 0, 0, '0, '0, 1, 12);

    do_flush(1, 1, 7, 20'h12345, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    do_read(7);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_flush(0, 0, 0, '0, '0, 0, 0);
      if ($urandom_range(0, 9) < 5)
        do_write($urandom_range(0, NW - 1), $urandom_range(0, 15), TW'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
      else
        do_read($urandom_range(0, 15));
    end

    // reset in the middle of a flush
    for (int w = 0; w < NW; w++) do_write(w, 40, TW'($urandom), {$urandom, $urandom, $urandom, $urandom});
    do_read(40);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    repeat (29) tick();
    check("busy_at_30", bus.busy_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    clear_model_valid();
    repeat (2) begin
      tick();
      check("rst_no_done", bus.flush_done_o, 0);
    end
    rstn = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_no_done", bus.flush_done_o, 0);
      check("post_rst_ready", bus.ready_o, 1);
    end
    $display("reset mid-flush done");
    do_read(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
